// File: rtl/mux_n_pkg.sv
// mux_n_pkg: shared constants and helpers for the N-channel registered mux.
// Latency: n/a (package only).
// Backpressure: n/a.
// Contents: mode encodings, maximum channel count, and a clog2 variant that
// never returns less than 1 (used to size the select and pointer).
package mux_n_pkg;

  localparam logic MODE_FIXED = 1'b0;
  localparam logic MODE_RR    = 1'b1;

  // Widest configuration the select and pointer logic is sized for.
  localparam int MAX_NUM_CH = 16;

  // $clog2 returns 0 for n=1; a zero-width select bus is illegal.
  function automatic int clog2_min1(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/mux_n_reg_rr_arbiter.sv
// rr_arbiter: rotating-priority search over a request vector, starting at ptr.
// Latency: purely combinational, zero cycles.
// Backpressure: none; the caller gates the grant with its own slot status.
// Ports:
//   req     in  NUM_CH  request vector (one bit per channel)
//   ptr     in  SEL_W   highest-priority channel this cycle (must be < NUM_CH)
//   gnt_idx out SEL_W   first requesting channel found from ptr upwards, wrapping
//   gnt_vld out 1       at least one request present
module rr_arbiter #(
  parameter int NUM_CH = 4,
  parameter int SEL_W  = 2
) (
  input  logic [NUM_CH-1:0] req,
  input  logic [SEL_W-1:0]  ptr,
  output logic [SEL_W-1:0]  gnt_idx,
  output logic              gnt_vld
);

  int                idx;
  logic [SEL_W-1:0]  idx_s;

  always_comb begin
    gnt_vld = 1'b0;
    gnt_idx = '0;
    idx     = 0;
    idx_s   = '0;
    // Visit ptr, ptr+1, ..., wrapping to 0; the first hit wins.
    for (int off = 0; off < NUM_CH; off++) begin
      idx   = (int'(ptr) + off) % NUM_CH;
      idx_s = SEL_W'(idx);
      if (!gnt_vld && req[idx_s]) begin
        gnt_vld = 1'b1;
        gnt_idx = idx_s;
      end
    end
  end

endmodule

// File: rtl/mux_n_reg.sv
// mux_n_reg: selects one of NUM_CH valid/ready channels into one registered output.
// Latency: 1 cycle from input transfer to out_data/out_valid.
// Backpressure: accepts a new word when the output is empty or being drained
//   (full throughput); stalls all inputs while out_valid && !out_ready.
// Ports:
//   sysclk, rst (sync, active-high); mode (0 fixed, 1 round-robin); sel (fixed index)
//   in_data/in_valid/in_ready  per-channel inputs, in_ready one-hot or zero
//   out_data/out_valid/out_ready  registered output handshake
// Optional: define MUX_N_REG_CHAN_ID_EN to add out_chan, the source channel index
//   registered with out_data.
module mux_n_reg
  import mux_n_pkg::*;
#(
  parameter int DATA_W = 8,
  parameter int NUM_CH = 4,
  parameter int SEL_W  = clog2_min1(NUM_CH)
) (
  input  logic                     sysclk,
  input  logic                     rst,
  input  logic                     mode,
  input  logic [SEL_W-1:0]         sel,
  input  logic [NUM_CH*DATA_W-1:0] in_data,
  input  logic [NUM_CH-1:0]        in_valid,
  output logic [NUM_CH-1:0]        in_ready,
  output logic [DATA_W-1:0]        out_data,
  output logic                     out_valid,
`ifdef MUX_N_REG_CHAN_ID_EN
  output logic [SEL_W-1:0]         out_chan,
`endif
  input  logic                     out_ready
);

  logic [DATA_W-1:0] out_data_q, out_data_d;
  logic              out_valid_q, out_valid_d;
  logic [SEL_W-1:0]  ptr_q, ptr_d;

  logic              slot_free;
  logic              fix_vld;
  logic              arb_vld;
  logic [SEL_W-1:0]  arb_idx;
  logic              gnt_vld;
  logic [SEL_W-1:0]  gnt_idx;
  logic [DATA_W-1:0] gnt_dat;

  rr_arbiter #(
    .NUM_CH (NUM_CH),
    .SEL_W  (SEL_W)
  ) u_arb (
    .req     (in_valid),
    .ptr     (ptr_q),
    .gnt_idx (arb_idx),
    .gnt_vld (arb_vld)
  );

  assign slot_free = !out_valid_q || out_ready;

  always_comb begin
    // An out-of-range sel matches no channel, so it can never grant.
    fix_vld = 1'b0;
    for (int i = 0; i < NUM_CH; i++) begin
      if (sel == SEL_W'(i) && in_valid[i]) fix_vld = 1'b1;
    end

    gnt_idx = (mode == MODE_RR) ? arb_idx : sel;
    // A grant always implies the granted valid is high, so grant == transfer.
    gnt_vld = !rst && slot_free && ((mode == MODE_RR) ? arb_vld : fix_vld);

    in_ready = '0;
    gnt_dat  = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      if (gnt_idx == SEL_W'(i)) begin
        in_ready[i] = gnt_vld;
        gnt_dat     = in_data[i*DATA_W +: DATA_W];
      end
    end
  end

  always_comb begin
    out_data_d  = out_data_q;
    out_valid_d = out_valid_q;
    ptr_d       = ptr_q;
    if (gnt_vld) begin
      // Covers both an empty slot and a same-cycle drain-and-refill.
      out_data_d  = gnt_dat;
      out_valid_d = 1'b1;
      if (mode == MODE_RR) begin
        ptr_d = (gnt_idx == SEL_W'(NUM_CH - 1)) ? '0 : gnt_idx + 1'b1;
      end
    end else if (out_ready) begin
      out_valid_d = 1'b0;
    end
  end

  always_ff @(posedge sysclk) begin
    if (rst) begin
      out_data_q  <= '0;
      out_valid_q <= 1'b0;
      ptr_q       <= '0;
    end else begin
      out_data_q  <= out_data_d;
      out_valid_q <= out_valid_d;
      ptr_q       <= ptr_d;
    end
  end

  assign out_data  = out_data_q;
  assign out_valid = out_valid_q;

`ifdef MUX_N_REG_CHAN_ID_EN
  logic [SEL_W-1:0] chan_q, chan_d;

  assign chan_d = gnt_vld ? gnt_idx : chan_q;

  always_ff @(posedge sysclk) begin
    if (rst) chan_q <= '0;
    else     chan_q <= chan_d;
  end

  assign out_chan = chan_q;
`endif

endmodule

// File: tb/tb_mux_n_reg.sv
// tb_mux_n_reg: directed test of mux_n_reg with NUM_CH=4, DATA_W=8.
// Inputs are driven 1 time unit after the rising edge; combinational in_ready
// is sampled 1 unit later, registered outputs 1 unit after the next edge.
module tb_mux_n_reg;

  localparam int DATA_W = 8;
  localparam int NUM_CH = 4;
  localparam int SEL_W  = 2;

  logic                     sysclk = 1'b0;
  logic                     rst;
  logic                     mode;
  logic [SEL_W-1:0]         sel;
  logic [NUM_CH*DATA_W-1:0] in_data;
  logic [NUM_CH-1:0]        in_valid;
  logic [NUM_CH-1:0]        in_ready;
  logic [DATA_W-1:0]        out_data;
  logic                     out_valid;
  logic                     out_ready;
`ifdef MUX_N_REG_CHAN_ID_EN
  logic [SEL_W-1:0]         out_chan;
`endif

  int n_checks = 0;
  int n_fail   = 0;

  always #5 sysclk = ~sysclk;

  mux_n_reg #(
    .DATA_W (DATA_W),
    .NUM_CH (NUM_CH)
  ) dut (
    .sysclk    (sysclk),
    .rst       (rst),
    .mode      (mode),
    .sel       (sel),
    .in_data   (in_data),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .out_data  (out_data),
    .out_valid (out_valid),
`ifdef MUX_N_REG_CHAN_ID_EN
    .out_chan  (out_chan),
`endif
    .out_ready (out_ready)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Advance to just after the next rising edge.
  task automatic step();
    @(posedge sysclk);
    #1;
  endtask

  // Let combinational outputs settle after an input change.
  task automatic settle();
    #1;
  endtask

  initial begin
    logic [7:0] rr_exp [5];
    rr_exp = '{8'h10, 8'h20, 8'h30, 8'h40, 8'h10};

    // Reset with every channel requesting.
    rst       = 1'b1;
    mode      = 1'b0;
    sel       = '0;
    in_valid  = 4'hF;
    in_data   = {8'h44, 8'h33, 8'h22, 8'h11};
    out_ready = 1'b1;
    step();
    check_eq("rst_out_valid", 32'(out_valid), 32'd0);
    check_eq("rst_out_data", 32'(out_data), 32'h00);
    check_eq("rst_in_ready_0", 32'(in_ready), 32'h0);
    step();
    check_eq("rst_in_ready_1", 32'(in_ready), 32'h0);
    check_eq("rst_ptr", 32'(dut.ptr_q), 32'd0);
    rst = 1'b0;

    // Fixed mode, sel=2.
    mode     = 1'b0;
    sel      = 2'd2;
    in_valid = 4'b0100;
    in_data  = {8'h00, 8'hA5, 8'h00, 8'h00};
    settle();
    check_eq("fix_in_ready_sel2", 32'(in_ready), 32'b0100);
    step();
    check_eq("fix_out_data", 32'(out_data), 32'hA5);
    check_eq("fix_out_valid", 32'(out_valid), 32'd1);

    // sel=3 with channel 3 idle: no grant, word drains.
    sel = 2'd3;
    settle();
    check_eq("fix_in_ready_sel3", 32'(in_ready), 32'h0);
    step();
    check_eq("fix_drain_valid", 32'(out_valid), 32'd0);
    check_eq("fix_drain_data_hold", 32'(out_data), 32'hA5);
    check_eq("fix_ptr_unchanged", 32'(dut.ptr_q), 32'd0);

    // Round-robin across four busy channels, no bubbles.
    mode     = 1'b1;
    in_valid = 4'hF;
    in_data  = {8'h40, 8'h30, 8'h20, 8'h10};
    for (int k = 0; k < 5; k++) begin
      settle();
      check_eq($sformatf("rr_in_ready_%0d", k), 32'(in_ready), 32'(1 << (k % 4)));
      step();
      check_eq($sformatf("rr_data_%0d", k), 32'(out_data), 32'(rr_exp[k]));
      check_eq($sformatf("rr_valid_%0d", k), 32'(out_valid), 32'd1);
    end
    check_eq("rr_ptr_after5", 32'(dut.ptr_q), 32'd1);

    // Load 0x20 from channel 1, then stall for three cycles.
    step();
    check_eq("stall_load", 32'(out_data), 32'h20);
    out_ready = 1'b0;
    for (int k = 0; k < 3; k++) begin
      settle();
      check_eq($sformatf("stall_in_ready_%0d", k), 32'(in_ready), 32'h0);
      step();
      check_eq($sformatf("stall_data_%0d", k), 32'(out_data), 32'h20);
      check_eq($sformatf("stall_valid_%0d", k), 32'(out_valid), 32'd1);
    end
    // Release: channel 2 granted in the same cycle as the drain.
    out_ready = 1'b1;
    settle();
    check_eq("release_in_ready", 32'(in_ready), 32'b0100);
    step();
    check_eq("release_data", 32'(out_data), 32'h30);
    check_eq("release_ptr", 32'(dut.ptr_q), 32'd3);

    // Skip from ptr=3 to channel 1.
    in_valid = 4'b0010;
    settle();
    check_eq("skip_in_ready", 32'(in_ready), 32'b0010);
    step();
    check_eq("skip_data", 32'(out_data), 32'h20);
    check_eq("skip_ptr", 32'(dut.ptr_q), 32'd2);

    // Wrap from ptr=2 through 3 to channel 0.
    in_valid = 4'b0001;
    settle();
    check_eq("wrap_in_ready", 32'(in_ready), 32'b0001);
    step();
    check_eq("wrap_data", 32'(out_data), 32'h10);
    check_eq("wrap_ptr", 32'(dut.ptr_q), 32'd1);

    // Channel 3 word, then stall, then reset during the stall.
    in_valid = 4'b1000;
    step();
    check_eq("ch3_data", 32'(out_data), 32'h40);
`ifdef MUX_N_REG_CHAN_ID_EN
    check_eq("ch3_out_chan", 32'(out_chan), 32'd3);
`endif
    in_valid  = 4'b0000;
    out_ready = 1'b0;
    step();
    check_eq("ch3_stall_valid", 32'(out_valid), 32'd1);
    rst      = 1'b1;
    in_valid = 4'hF;
    settle();
    check_eq("midrst_in_ready", 32'(in_ready), 32'h0);
    step();
    check_eq("midrst_valid", 32'(out_valid), 32'd0);
    check_eq("midrst_data", 32'(out_data), 32'h00);
    check_eq("midrst_ptr", 32'(dut.ptr_q), 32'd0);
`ifdef MUX_N_REG_CHAN_ID_EN
    check_eq("midrst_out_chan", 32'(out_chan), 32'd0);
`endif
    rst = 1'b0;
    step();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
